// File: rtl/aes_block_packer.sv
// AES block packer: gathers 32-bit stream words into a 128-bit cipher block,
// hands it to the cipher core, and serializes the 128-bit result back to words.
module aes_block_packer #(
    parameter int BYTE_SWAP = 0,
    parameter int LEN_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_bytes_i,
    input  logic [31:0]      in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [127:0]     blk_data_o,
    output logic             blk_valid_o,
    input  logic             blk_ready_i,
    input  logic [127:0]     res_data_i,
    input  logic             res_valid_i,
    output logic             res_ready_o,
    output logic [31:0]      out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      block_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CIPHER_REQ,
        CIPHER_WAIT,
        DRAIN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_rem;
    logic [1:0]       r_word_cnt;
    logic [3:0][31:0] r_blk;        // element 3 is slot 0 (MSW)
    logic [3:0][31:0] r_res;
    logic [15:0]      r_block_cnt;

    logic w_in_fire;
    logic w_blk_fire;
    logic w_res_fire;
    logic w_out_fire;
    logic w_last_word;

    function automatic logic [31:0] f_swap(input logic [31:0] w);
        if (BYTE_SWAP != 0) begin
            return {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return w;
    endfunction

    assign w_in_fire  = (r_state == FILL)        && in_valid_i;
    assign w_blk_fire = (r_state == CIPHER_REQ)  && blk_ready_i;
    assign w_res_fire = (r_state == CIPHER_WAIT) && res_valid_i;
    assign w_out_fire = (r_state == DRAIN)       && out_ready_i;

    // The word in flight closes the block once the slots are full or the job's
    // remaining bytes fit inside it.
    assign w_last_word = (r_word_cnt == 2'd3) || (r_rem <= LEN_W'(4));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next      = r_state;
        in_ready_o  = 1'b0;
        blk_valid_o = 1'b0;
        res_ready_o = 1'b0;
        out_valid_o = 1'b0;
        done_o      = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_next = (len_bytes_i == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                in_ready_o = 1'b1;
                if (in_valid_i && w_last_word) begin
                    w_next = CIPHER_REQ;
                end
            end
            CIPHER_REQ: begin
                blk_valid_o = 1'b1;
                if (blk_ready_i) begin
                    w_next = CIPHER_WAIT;
                end
            end
            CIPHER_WAIT: begin
                res_ready_o = 1'b1;
                if (res_valid_i) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid_o = 1'b1;
                if (out_ready_i && (r_word_cnt == 2'd3)) begin
                    w_next = (r_rem == '0) ? DONE : FILL;
                end
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // NOTE: the block and result buffers are reset too, since blk_data_o exposes
    // the block buffer directly and must read zero after reset or clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem       <= '0;
            r_word_cnt  <= '0;
            r_blk       <= '0;
            r_res       <= '0;
            r_block_cnt <= '0;
        end else if (clear) begin
            r_rem       <= '0;
            r_word_cnt  <= '0;
            r_blk       <= '0;
            r_res       <= '0;
            r_block_cnt <= '0;
        end else begin
            // NOTE: state elements use non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            if ((r_state == IDLE) && start_i) begin
                r_rem       <= len_bytes_i;
                r_word_cnt  <= '0;
                r_block_cnt <= '0;
            end
            if (w_in_fire) begin
                r_blk[2'd3 - r_word_cnt] <= f_swap(in_data_i);
                r_word_cnt               <= r_word_cnt + 2'd1;
                r_rem                    <= (r_rem >= LEN_W'(4)) ? (r_rem - LEN_W'(4)) : '0;
            end
            if (w_blk_fire) begin
                r_word_cnt <= r_word_cnt;
            end
            if (w_res_fire) begin
                r_res      <= res_data_i;
                r_word_cnt <= '0;
            end
            if (w_out_fire) begin
                r_word_cnt <= r_word_cnt + 2'd1;
                if (r_word_cnt == 2'd3) begin
                    r_block_cnt <= r_block_cnt + 16'd1;
                    r_blk       <= '0;
                end
            end
        end
    end

    assign blk_data_o  = r_blk;
    assign out_data_o  = (r_state == DRAIN) ? f_swap(r_res[2'd3 - r_word_cnt]) : 32'd0;
    assign block_cnt_o = r_block_cnt;

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: randomized jobs against a queue-based
// reference model, plus a directed byte-swap scenario on a second instance.
`timescale 1ns/1ps
module tb_aes_block_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // Instance with BYTE_SWAP = 0
    logic         clear, start_i, in_valid_i, in_ready_o;
    logic [31:0]  len_bytes_i, in_data_i, out_data_o;
    logic [127:0] blk_data_o, res_data_i;
    logic         blk_valid_o, blk_ready_i, res_valid_i, res_ready_o;
    logic         out_valid_o, out_ready_i, busy_o, done_o;
    logic [15:0]  block_cnt_o;

    // Instance with BYTE_SWAP = 1, LEN_W = 16
    logic         s_clear, s_start, s_in_valid, s_in_ready;
    logic [15:0]  s_len;
    logic [31:0]  s_in_data, s_out_data;
    logic [127:0] s_blk_data, s_res_data;
    logic         s_blk_valid, s_blk_ready, s_res_valid, s_res_ready;
    logic         s_out_valid, s_out_ready, s_busy, s_done;
    logic [15:0]  s_block_cnt;

    aes_block_packer #(.BYTE_SWAP(0), .LEN_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
        .len_bytes_i(len_bytes_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .blk_data_o(blk_data_o), .blk_valid_o(blk_valid_o),
        .blk_ready_i(blk_ready_i), .res_data_i(res_data_i), .res_valid_i(res_valid_i),
        .res_ready_o(res_ready_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o), .block_cnt_o(block_cnt_o)
    );

    aes_block_packer #(.BYTE_SWAP(1), .LEN_W(16)) dut_swap (
        .clk(clk), .reset_n(reset_n), .clear(s_clear), .start_i(s_start),
        .len_bytes_i(s_len), .in_data_i(s_in_data), .in_valid_i(s_in_valid),
        .in_ready_o(s_in_ready), .blk_data_o(s_blk_data), .blk_valid_o(s_blk_valid),
        .blk_ready_i(s_blk_ready), .res_data_i(s_res_data), .res_valid_i(s_res_valid),
        .res_ready_o(s_res_ready), .out_data_o(s_out_data), .out_valid_o(s_out_valid),
        .out_ready_i(s_out_ready), .busy_o(s_busy), .done_o(s_done), .block_cnt_o(s_block_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] src_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic check_idle_zero(input string where);
        check({where, "_in_ready"},  in_ready_o,  0);
        check({where, "_blk_valid"}, blk_valid_o, 0);
        check({where, "_res_ready"}, res_ready_o, 0);
        check({where, "_out_valid"}, out_valid_o, 0);
        check({where, "_done"},      done_o,      0);
        check({where, "_busy"},      busy_o,      0);
        check({where, "_blk_data"},  blk_data_o,  0);
        check({where, "_out_data"},  out_data_o,  0);
        check({where, "_block_cnt"}, block_cnt_o, 0);
    endtask

    // Runs one job on the BYTE_SWAP=0 instance. The core model answers each block
    // with its bitwise complement. clr_after >= 0 asserts clear once that many
    // output words have been accepted.
    task automatic run_job(input int len, input bit rnd_words, input int in_pct,
                           input int out_pct, input int blk_dly, input int clr_after,
                           input bit chk_lat);
        logic [127:0] exp_blk[$];
        logic [31:0]  exp_out[$];
        logic [127:0] blk;
        int n_words, n_blocks, in_idx, blk_idx, res_idx, out_idx, cyc, blk_wait, t_last_in;
        bit done_seen, cleared, prev_blk_v, prev_res_r, prev_out_v;

        n_words  = (len + 3) / 4;
        n_blocks = (n_words + 3) / 4;
        if (rnd_words) begin
            src_q.delete();
            for (int i = 0; i < n_words; i++) src_q.push_back($urandom);
        end
        for (int b = 0; b < n_blocks; b++) begin
            blk = '0;
            for (int k = 0; k < 4; k++)
                if (4 * b + k < n_words) blk[127 - 32 * k -: 32] = src_q[4 * b + k];
            exp_blk.push_back(blk);
            for (int k = 0; k < 4; k++) exp_out.push_back(~blk[127 - 32 * k -: 32]);
        end

        @(negedge clk);
        start_i     = 1'b1;
        len_bytes_i = len;
        @(negedge clk);
        start_i     = 1'b0;
        len_bytes_i = $urandom;

        in_idx = 0; blk_idx = 0; res_idx = 0; out_idx = 0; blk_wait = 0; t_last_in = -100;
        done_seen = 1'b0; cleared = 1'b0;
        prev_blk_v = 1'b0; prev_res_r = 1'b0; prev_out_v = 1'b0;
        cyc = 1;
        while (!done_seen && !cleared && cyc < 4000) begin
            if (done_o) begin
                done_seen = 1'b1;
                check("done_out_words", out_idx, n_blocks * 4);
                check("done_in_words", in_idx, n_words);
                check("done_blocks", blk_idx, n_blocks);
                check("done_block_cnt", block_cnt_o, n_blocks);
                check("done_busy", busy_o, 1);
                if (len == 0) check("len0_done_latency", cyc, 1);
                in_valid_i = 1'b0; blk_ready_i = 1'b0; res_valid_i = 1'b0; out_ready_i = 1'b0;
            end else begin
                if (in_ready_o)
                    check("in_ready_allowed",
                          (in_idx < n_words) && (in_idx < 4 * (out_idx / 4 + 1)), 1);
                in_valid_i = (in_idx < n_words) && (int'($urandom_range(99, 0)) < in_pct);
                in_data_i  = in_valid_i ? src_q[in_idx] : $urandom;
                if (in_valid_i && in_ready_o) begin
                    if (((in_idx + 1) % 4 == 0) || (in_idx + 1 == n_words)) t_last_in = cyc;
                    in_idx++;
                end

                blk_ready_i = 1'b0;
                if (blk_valid_o) begin
                    check("blk_in_range", blk_idx < n_blocks, 1);
                    if (blk_idx < n_blocks) check("blk_data", blk_data_o, exp_blk[blk_idx]);
                    if (chk_lat && !prev_blk_v) check("blk_latency", cyc - t_last_in, 1);
                    blk_ready_i = (blk_wait >= blk_dly);
                    blk_wait++;
                    if (blk_ready_i) begin
                        blk_idx++;
                        blk_wait = 0;
                    end
                end

                res_valid_i = 1'b0;
                if (res_ready_o) begin
                    if (chk_lat && !prev_res_r) check("res_latency", cyc - t_last_in, 2);
                    res_valid_i = (in_pct == 100) || (int'($urandom_range(9, 0)) < 7);
                    res_data_i  = (res_idx < n_blocks) ? ~exp_blk[res_idx] : '0;
                    if (res_valid_i) res_idx++;
                end

                out_ready_i = 1'b0;
                if (out_valid_o) begin
                    check("out_in_range", out_idx < exp_out.size(), 1);
                    if (out_idx < exp_out.size()) check("out_data", out_data_o, exp_out[out_idx]);
                    if (chk_lat && !prev_out_v) check("out_latency", cyc - t_last_in, 3);
                    if (clr_after >= 0 && out_idx == clr_after) begin
                        clear   = 1'b1;
                        cleared = 1'b1;
                    end else begin
                        out_ready_i = (int'($urandom_range(99, 0)) < out_pct);
                        if (out_ready_i) out_idx++;
                    end
                end
            end
            prev_blk_v = blk_valid_o;
            prev_res_r = res_ready_o;
            prev_out_v = out_valid_o;
            @(negedge clk);
            cyc++;
        end

        in_valid_i = 1'b0; blk_ready_i = 1'b0; res_valid_i = 1'b0; out_ready_i = 1'b0;
        if (cleared) begin
            clear = 1'b0;
            check_idle_zero("after_clear");
        end else begin
            check("job_done_seen", done_seen, 1);
            check("done_one_cycle", done_o, 0);
            check("idle_busy", busy_o, 0);
            check("block_cnt_hold", block_cnt_o, n_blocks);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clear = 1'b0; start_i = 1'b0; len_bytes_i = '0; in_data_i = '0; in_valid_i = 1'b0;
        blk_ready_i = 1'b0; res_data_i = '0; res_valid_i = 1'b0; out_ready_i = 1'b0;
        s_clear = 1'b0; s_start = 1'b0; s_len = '0; s_in_data = '0; s_in_valid = 1'b0;
        s_blk_ready = 1'b0; s_res_data = '0; s_res_valid = 1'b0; s_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");
        check("swap_post_reset_busy", s_busy, 0);
        check("swap_post_reset_blk", s_blk_data, 0);

        // Single full block, all handshakes ready, latency checked
        src_q = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        run_job(16, 1'b0, 100, 100, 0, -1, 1'b1);

        // 2.5 blocks: third block padded with two zero words
        run_job(40, 1'b1, 100, 100, 0, -1, 1'b0);

        // Zero-length job
        run_job(0, 1'b1, 100, 100, 0, -1, 1'b0);

        // Backpressure on every interface, including a non-multiple-of-4 length
        run_job(52, 1'b1, 50, 50, 5, -1, 1'b0);
        run_job(23, 1'b1, 60, 50, 2, -1, 1'b0);
        run_job(70, 1'b1, 80, 30, 1, -1, 1'b0);

        // Clear in DRAIN after two output words, then a clean job
        run_job(16, 1'b1, 100, 100, 0, 2, 1'b0);
        run_job(16, 1'b1, 100, 100, 0, -1, 1'b0);

        // Byte-swap instance; start_i pulsed in FILL with a different length
        @(negedge clk);
        s_start = 1'b1; s_len = 16'd4;
        @(negedge clk);
        check("swap_fill_ready", s_in_ready, 1);
        s_start = 1'b1; s_len = 16'd100;
        @(negedge clk);
        s_start = 1'b0;
        check("swap_fill_ready_after_start", s_in_ready, 1);
        s_in_valid = 1'b1; s_in_data = 32'h01020304;
        @(negedge clk);
        s_in_valid = 1'b0;
        check("swap_in_ready_drop", s_in_ready, 0);
        check("swap_blk_valid", s_blk_valid, 1);
        check("swap_blk_data", s_blk_data, {swap32(32'h01020304), 96'd0});
        s_blk_ready = 1'b1;
        @(negedge clk);
        s_blk_ready = 1'b0;
        check("swap_res_ready", s_res_ready, 1);
        s_res_valid = 1'b1;
        s_res_data  = {swap32(32'h01020304), 96'd0};
        @(negedge clk);
        s_res_valid = 1'b0;
        check("swap_out_valid", s_out_valid, 1);
        check("swap_out_word0", s_out_data, 32'h01020304);
        s_out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("swap_out_pad_valid", s_out_valid, 1);
            check("swap_out_pad_word", s_out_data, 0);
        end
        @(negedge clk);
        s_out_ready = 1'b0;
        check("swap_done", s_done, 1);
        check("swap_block_cnt", s_block_cnt, 1);
        @(negedge clk);
        check("swap_done_drop", s_done, 0);
        check("swap_idle_busy", s_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
Name: aes_block_packer

Overview:
Datapath stage between the HWPE input/output streamers and the AES cipher core, driven by the engine FSM's start/clear. It gathers 32-bit words from the input source stream into one 128-bit state block and presents that block to the cipher core over a valid/ready handshake. It then captures the 128-bit cipher result and serializes it back into four 32-bit words for the output sink stream. It tracks the byte length of the job and zero-pads a partial final block.

Parameters:
BYTE_SWAP, 0, 1 = reverse byte order within each 32-bit word on both ingest and egress; 0 = pass through unchanged
LEN_W, 32, width of the job byte-length input

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
clear  in  1  synchronous clear: return to IDLE, zero all counters and buffers
start_i  in  1  single-cycle job start; sampled only in IDLE
len_bytes_i  in  LEN_W  job length in bytes; captured on accepted start_i
in_data_i  in  32  input stream word
in_valid_i  in  1  input stream valid
in_ready_o  out  1  input stream ready
blk_data_o  out  128  assembled block; word 0 in [127:96], word 3 in [31:0]
blk_valid_o  out  1  block valid to cipher core
blk_ready_i  in  1  cipher core accepts block
res_data_i  in  128  cipher result, same word ordering as blk_data_o
res_valid_i  in  1  result valid
res_ready_o  out  1  result ready
out_data_o  out  32  output stream word
out_valid_o  out  1  output stream valid
out_ready_i  in  1  output stream ready
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse at job end
block_cnt_o  out  16  number of blocks fully drained in the current job

Behaviour:
- Reset/clear: state IDLE. All outputs 0: in_ready_o, blk_valid_o, res_ready_o, out_valid_o, done_o, busy_o, blk_data_o, out_data_o, block_cnt_o. Internal buffers, word_cnt and remaining-byte register are zeroed. clear has priority over every other event in the same cycle.
- States: IDLE, FILL, CIPHER_REQ, CIPHER_WAIT, DRAIN, DONE.
- IDLE:
  - On start_i, latch rem = len_bytes_i.
  - If len_bytes_i == 0, go to DONE.
  - Otherwise go to FILL.
- FILL:
  - in_ready_o = 1.
  - A word transfers when in_valid_i && in_ready_o. It is stored at slot word_cnt (slot 0 = MSW), word_cnt increments, and rem decrements by 4, saturating at 0.
  - need = 4 if rem >= 16 at block start, else ceil(rem/4).
  - When the need-th word transfers, go to CIPHER_REQ. Unfilled slots read as 0, and in_ready_o drops in the following cycle.
  - Input words beyond need are never accepted in that block.
- CIPHER_REQ:
  - blk_valid_o = 1 and blk_data_o is held stable until blk_ready_i.
  - On handshake, go to CIPHER_WAIT.
- CIPHER_WAIT:
  - res_ready_o = 1.
  - On res_valid_i, capture res_data_i into the output buffer, reset word_cnt to 0, go to DRAIN.
- DRAIN:
  - out_valid_o = 1 and out_data_o = result word[word_cnt].
  - Data is held stable while out_ready_i = 0; the word advances only on handshake.
  - All 4 words are always emitted, including for a padded block.
  - After the 4th handshake, block_cnt_o increments and the block buffer clears. If rem == 0, go to DONE; otherwise go to FILL with word_cnt = 0.
- DONE: done_o = 1 for exactly one cycle, then IDLE. block_cnt_o holds until the next accepted start_i, which zeroes it.
- start_i outside IDLE is ignored.
- Single-buffered: at most one block in flight. Ingest of block N+1 starts only after block N is fully drained.
- Minimum latency, all handshakes ready (cycle of the 4th input transfer = cycle 0):
  - blk_valid_o rises at cycle 1.
  - With blk_ready_i = 1, res_ready_o is high at cycle 2.
  - If res_valid_i is high at cycle 2, the first out_valid_o is at cycle 3.
- BYTE_SWAP = 1 applies {b0,b1,b2,b3} to each word, on input before storage and on output after selection.
- block_cnt_o wraps modulo 2^16.
- If len_bytes_i is not a multiple of 4, the final partial word is accepted whole; byte masking is the sink's responsibility.

Test Plan:
- len=16, in words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, core ready -> blk_data_o = 0x00112233_44556677_8899AABB_CCDDEEFF. Core echoes res_data = blk_data XOR all-ones -> out words 0xFFEEDDCC, 0xBBAA9988, 0x77665544, 0x33221100 in order, then done_o pulse, block_cnt_o = 1.
- len=40 (2.5 blocks) -> 10 input words accepted, 3 blocks presented. Third block = {w8, w9, 0, 0}. 12 output words, block_cnt_o = 3.
- len=0 start -> no in_ready_o, no blk_valid_o; done_o rises 1 cycle after start, busy_o high for that 1 cycle only.
- Backpressure: in_valid_i toggling, blk_ready_i delayed 5 cycles, out_ready_i 50% random -> blk_data_o and out_data_o stable while stalled, no words lost or duplicated, order preserved.
- clear asserted in DRAIN after 2 output words -> next cycle IDLE, all outputs 0. A new start with len=16 completes normally with block_cnt_o = 1.
- BYTE_SWAP=1, input 0x01020304 -> stored as 0x04030201. Echo core -> output 0x01020304. start_i pulsed during FILL -> ignored, rem unchanged.
